// File: rtl/shift_seq_pkg.sv
// Shared types, counter-width helper and reset constants for the shift-register sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam logic RST_SI       = 1'b0;
  localparam logic RST_SHIFT    = 1'b0;
  localparam logic RST_BUSY     = 1'b0;
  localparam logic RST_DONE     = 1'b0;
  localparam logic RST_TX_READY = 1'b1;
  localparam logic RST_RX_BIT   = 1'b0;
  localparam logic RST_RX_VALID = 1'b0;

endpackage

// File: rtl/shift_seq_divider.sv
// Bit-period counter: tick is a registered flag, high in the last clk cycle of each period.
module shift_seq_divider
  import shift_seq_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] cnt_nxt_s;
  logic             tick_r;

  // Next count: restart on clear or when not running, wrap at the period end.
  always_comb begin
    cnt_nxt_s = {DIV_W{1'b0}};
    if (clr || !run) begin
      cnt_nxt_s = {DIV_W{1'b0}};
    end else if (div_cnt_r == LAST) begin
      cnt_nxt_s = {DIV_W{1'b0}};
    end else begin
      cnt_nxt_s = div_cnt_r + DIV_W'(1);
    end
  end

  // Tick is computed one cycle ahead so it lines up with the count it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      tick_r    <= RST_SHIFT;
    end else begin
      div_cnt_r <= cnt_nxt_s;
      tick_r    <= run && (cnt_nxt_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial shift-register sequencer: MSB-first si with one shift strobe per bit, done pulse at end.
// Optional po readback capture is enabled by defining SHIFT_SEQ_READBACK_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             abort,
  input  logic             po,
  output logic             si,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int BIT_W = cnt_width(WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_e           state_r;
  state_e           state_next_s;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [WIDTH-1:0] word_r;
  logic             tx_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             step_s;
  logic             run_s;

  shift_seq_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run_s),
    .clr  (accept_s),
    .tick (shift)
  );

  // Next-state logic; abort outranks the final shift so no done is produced.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_valid && tx_ready_r) begin
          accept_s     = 1'b1;
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next_s = IDLE;
        end else if (shift) begin
          step_s       = 1'b1;
          state_next_s = (bit_cnt_r == LAST_BIT) ? DONE : SHIFT;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    run_s = (state_next_s == SHIFT);
  end

  // State, status flags and data shifter; si is the shifter MSB, cleared whenever a transfer ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bit_cnt_r  <= {BIT_W{1'b0}};
      word_r     <= {WIDTH{RST_SI}};
      tx_ready_r <= RST_TX_READY;
      busy_r     <= RST_BUSY;
      done_r     <= RST_DONE;
    end else begin
      state_r    <= state_next_s;
      tx_ready_r <= (state_next_s == IDLE);
      busy_r     <= run_s;
      done_r     <= (state_next_s == DONE);
      if (accept_s) begin
        word_r    <= tx_data;
        bit_cnt_r <= {BIT_W{1'b0}};
      end else if (!run_s) begin
        word_r    <= {WIDTH{1'b0}};
        bit_cnt_r <= bit_cnt_r;
      end else if (step_s) begin
        word_r    <= {word_r[WIDTH-2:0], 1'b0};
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end else begin
        word_r    <= word_r;
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  assign si       = word_r[WIDTH-1];
  assign tx_ready = tx_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;

`ifdef SHIFT_SEQ_READBACK_EN
  logic [WIDTH-1:0] rx_data_r;
  logic             rx_valid_r;

  // po is sampled on each shift edge, i.e. the bit presented before that shift takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r  <= {WIDTH{RST_RX_BIT}};
      rx_valid_r <= RST_RX_VALID;
    end else begin
      if (accept_s) begin
        rx_data_r <= {WIDTH{1'b0}};
      end else if (shift) begin
        rx_data_r <= {rx_data_r[WIDTH-2:0], po};
      end else begin
        rx_data_r <= rx_data_r;
      end
      rx_valid_r <= (state_next_s == DONE);
    end
  end

  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
`else
  logic unused_po_s;
  assign unused_po_s = po;
  assign rx_data     = {WIDTH{RST_RX_BIT}};
  assign rx_valid    = RST_RX_VALID;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (CLK_DIV=1 and CLK_DIV=4 instances).
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, abort, v1, v4, load;
  logic [7:0] tx_data, preload, sr1;
  logic       po1, po4;
  logic       rdy1, si1, sh1, busy1, done1, rxv1;
  logic       rdy4, si4, sh4, busy4, done4, rxv4;
  logic [7:0] rx1, rx4;
  int         checks_n = 0;
  int         fails_n  = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v1), .tx_ready(rdy1),
    .abort(abort), .po(po1), .si(si1), .shift(sh1), .busy(busy1), .done(done1),
    .rx_data(rx1), .rx_valid(rxv1)
  );

  shift_seq_ctrl #(.WIDTH(8), .CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v4), .tx_ready(rdy4),
    .abort(abort), .po(po4), .si(si4), .shift(sh4), .busy(busy4), .done(done4),
    .rx_data(rx4), .rx_valid(rxv4)
  );

  // External shift register model: po is its MSB, it shifts si in on every shift edge.
  always @(posedge clk) begin
    if (load) sr1 <= preload;
    else if (sh1) sr1 <= {sr1[6:0], si1};
  end
  assign po1 = sr1[7];
  assign po4 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      fails_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d);
    tx_data = d;
    if (sel) v4 = 1'b1;
    else v1 = 1'b1;
    step();
    v1 = 1'b0;
    v4 = 1'b0;
  endtask

  // Called in cycle 1 after an accept; stops at the done cycle (dk=0 if done never came).
  task automatic collect(input bit sel, output logic [7:0] sis, output int nsh, output int dk,
                         output int bad, output logic rxv, output logic [7:0] rx);
    int   d;
    logic s, h, prev_si, prev_sh;
    d = sel ? 4 : 1;
    sis = 8'h00; nsh = 0; dk = 0; bad = 0; rxv = 1'b0; rx = 8'h00;
    prev_si = sel ? si4 : si1;
    prev_sh = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      s = sel ? si4 : si1;
      h = sel ? sh4 : sh1;
      if (h && (k % d != 0)) bad++;
      if (k > 1 && s !== prev_si && !prev_sh) bad++;
      if (h) begin
        sis = {sis[6:0], s};
        nsh++;
      end
      if (sel ? done4 : done1) begin
        dk  = k;
        rxv = sel ? rxv4 : rxv1;
        rx  = sel ? rx4 : rx1;
        break;
      end
      prev_si = s;
      prev_sh = h;
      step();
    end
  endtask

  logic [7:0] sis, rx;
  logic       rxv;
  int         nsh, dk, bad, n, acck;

  initial begin
    rst_n = 1'b0; abort = 1'b0; v1 = 1'b0; v4 = 1'b0;
    tx_data = 8'h00; load = 1'b1; preload = 8'h00;
    repeat (3) step();
    load  = 1'b0;
    rst_n = 1'b1;
    chk("reset_d1", {rdy1, si1, sh1, busy1, done1, rxv1}, 6'b100000);
    chk("reset_d4", {rdy4, si4, sh4, busy4, done4, rxv4}, 6'b100000);
    chk("reset_rx", rx1, 8'h00);
    step();
    chk("idle_hold", {rdy1, busy1, done1}, 3'b100);

    // CLK_DIV=1, A5
    send(1'b0, 8'hA5);
    chk("a5_busy", {rdy1, busy1, sh1}, 3'b011);
    collect(1'b0, sis, nsh, dk, bad, rxv, rx);
    chk("a5_si", sis, 8'hA5);
    chk("a5_nshift", nsh, 8);
    chk("a5_done_cyc", dk, 9);
    chk("a5_timing", bad, 0);
    chk("a5_done_flags", {rdy1, busy1, sh1, si1}, 4'b0000);
    step();
    chk("a5_ready_after", {rdy1, done1}, 2'b10);

    // CLK_DIV=4, 81
    send(1'b1, 8'h81);
    collect(1'b1, sis, nsh, dk, bad, rxv, rx);
    chk("d4_si", sis, 8'h81);
    chk("d4_nshift", nsh, 8);
    chk("d4_done_cyc", dk, 33);
    chk("d4_timing", bad, 0);
    step();

    // Abort after three shift pulses
    send(1'b0, 8'hF0);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_flags", {sh1, si1, busy1, done1, rdy1}, 5'b00001);
    chk("abort_idle_d4", {rdy4, busy4}, 2'b10);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done1) n++;
      step();
    end
    chk("abort_no_done", n, 0);

    // Abort coincident with the final shift cycle
    send(1'b0, 8'hFF);
    repeat (7) step();
    chk("last_shift_live", sh1, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_last", {done1, rdy1, busy1, sh1}, 4'b0100);
    step();
    chk("abort_last_nodone", done1, 1'b0);

    // New transfer after abort
    send(1'b0, 8'h3C);
    collect(1'b0, sis, nsh, dk, bad, rxv, rx);
    chk("3c_si", sis, 8'h3C);
    chk("3c_done_cyc", dk, 9);
    step();

    // Readback of a preloaded shift register
    preload = 8'hC3;
    load = 1'b1;
    step();
    load = 1'b0;
    send(1'b0, 8'h00);
    collect(1'b0, sis, nsh, dk, bad, rxv, rx);
    chk("rb_done_cyc", dk, 9);
    chk("rb_rx", rx, RB ? 8'hC3 : 8'h00);
    chk("rb_rxv", rxv, RB);
    step();
    step();
    chk("rb_rx_hold", {rxv1, rx1}, {1'b0, (RB ? 8'hC3 : 8'h00)});

    // Back-to-back with tx_valid held
    tx_data = 8'h01;
    v1 = 1'b1;
    step();
    chk("b2b_rx_clear", rx1, 8'h00);
    tx_data = 8'hFE;
    dk = 0;
    acck = -100;
    for (int k = 1; k <= 40; k++) begin
      if (done1) dk = k;
      if (rdy1) begin
        acck = k;
        break;
      end
      step();
    end
    chk("b2b_gap", acck - dk, 1);
    step();
    v1 = 1'b0;
    collect(1'b0, sis, nsh, dk, bad, rxv, rx);
    chk("b2b_si", sis, 8'hFE);
    chk("b2b_done_cyc", dk, 9);
    step();

    // Asynchronous reset while bit 5 is on the wire
    send(1'b0, 8'h5A);
    repeat (5) step();
    chk("pre_rst_busy", {busy1, sh1}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {rdy1, si1, sh1, busy1, done1, rxv1}, 6'b100000);
    chk("async_rst_rx", rx1, 8'h00);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done1) n++;
      step();
    end
    chk("rst_no_done", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule
